// File: rtl/ym3438_arb_pkg.sv
// Shared types, default timing constants and helpers for the YM3438 bus arbiter.
package ym3438_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_WR  = 3'd1,
        ST_ADDR_GAP = 3'd2,
        ST_DATA_WR  = 3'd3,
        ST_BUSY     = 3'd4
    } arb_state_t;

    // Two chip cycles of 6 MCLK so the core's c1/c2 synchroniser sees the strobe.
    localparam int DEF_WR_PULSE  = 12;
    localparam int DEF_GAP       = 12;
    // 32 busy-counter cycles x 6 MCLK.
    localparam int DEF_BUSY_WAIT = 192;

    // Width of a down-counter able to hold the largest of the three delays.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ym3438_arb_rr.sv
// Two-port round-robin picker. Purely combinational; the caller owns the pointer.
module ym3438_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_next_ptr
);

    // Pointer port wins a tie; after any grant the pointer moves to the other port.
    always_comb begin
        o_grant    = 2'b00;
        o_next_ptr = i_ptr;
        if (i_req[0] && i_req[1]) begin
            o_grant    = i_ptr ? 2'b10 : 2'b01;
            o_next_ptr = ~i_ptr;
        end else if (i_req[0]) begin
            o_grant    = 2'b01;
            o_next_ptr = 1'b1;
        end else if (i_req[1]) begin
            o_grant    = 2'b10;
            o_next_ptr = 1'b0;
        end
    end

endmodule

// File: rtl/ym3438_bus_arb.sv
// Sequencer and two-port arbiter driving the YM3438 host write pins.
// Each posted write becomes an address strobe, a gap, a data strobe and a busy
// hold-off; the address strobe is skipped when the chip already has that
// {bank, reg} latched from the previous write. All outputs are registered and
// are computed from the next state so a strobe starts the cycle after the grant.
// Request handshake: i_req[p] is a level held until o_ack[p] pulses for one
// cycle; it is only sampled in IDLE and a latched write always completes.
module ym3438_bus_arb
    import ym3438_arb_pkg::*;
#(
    parameter int WR_PULSE  = DEF_WR_PULSE,
    parameter int GAP       = DEF_GAP,
    parameter int BUSY_WAIT = DEF_BUSY_WAIT
) (
    input  logic            i_mclk,
    input  logic            i_ic,
    input  logic [1:0]      i_req,
    input  logic [1:0]      i_bank,
    input  logic [1:0][7:0] i_reg,
    input  logic [1:0][7:0] i_val,
    output logic [1:0]      o_ack,
    output logic            o_busy,
    output logic            o_cs,
    output logic            o_wr,
    output logic            o_rd,
    output logic [1:0]      o_address,
    output logic [7:0]      o_data,
    output arb_state_t      o_dbg_state
);

    localparam int CW = cnt_width(WR_PULSE, GAP, BUSY_WAIT);
    localparam logic [CW-1:0] PULSE_LD = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP - 1);
    localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_WAIT - 1);

    arb_state_t      r_state, w_next_state;
    logic [CW-1:0]   r_cnt, w_next_cnt;
    logic            r_ptr, r_win;
    logic            r_bank, r_last_bank, r_last_valid;
    logic [7:0]      r_reg, r_val, r_last_reg;
    logic            r_cs, r_wr, r_busy;
    logic [1:0]      r_ack, r_address;
    logic [7:0]      r_data;

    logic [1:0]      w_grant;
    logic            w_next_ptr, w_win_idx, w_latch, w_skip, w_done;
    logic            w_sel_bank, w_nbank;
    logic [7:0]      w_sel_reg, w_sel_val, w_nreg, w_nval;

    ym3438_arb_rr u_rr (
        .i_req      (i_req),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    assign w_win_idx  = w_grant[1];
    assign w_sel_bank = i_bank[w_win_idx];
    assign w_sel_reg  = i_reg[w_win_idx];
    assign w_sel_val  = i_val[w_win_idx];
    assign w_skip     = r_last_valid && ({w_sel_bank, w_sel_reg} == {r_last_bank, r_last_reg});
    assign w_done     = (r_state == ST_DATA_WR) && (r_cnt == '0);

    // Values the outputs will present after this edge (fresh on a grant).
    assign w_nbank = w_latch ? w_sel_bank : r_bank;
    assign w_nreg  = w_latch ? w_sel_reg  : r_reg;
    assign w_nval  = w_latch ? w_sel_val  : r_val;

    // Next-state logic: each timed state reloads the shared counter on entry.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req) begin
                    w_latch      = 1'b1;
                    w_next_state = w_skip ? ST_DATA_WR : ST_ADDR_WR;
                    w_next_cnt   = PULSE_LD;
                end
            end
            ST_ADDR_WR: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_ADDR_GAP;
                    w_next_cnt   = GAP_LD;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            ST_ADDR_GAP: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_DATA_WR;
                    w_next_cnt   = PULSE_LD;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            ST_DATA_WR: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_BUSY;
                    w_next_cnt   = BUSY_LD;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // State, counter, latched write and last-written-address tracking.
    always_ff @(posedge i_mclk) begin
        if (!i_ic) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ptr        <= 1'b0;
            r_win        <= 1'b0;
            r_bank       <= 1'b0;
            r_reg        <= 8'h00;
            r_val        <= 8'h00;
            r_last_valid <= 1'b0;
            r_last_bank  <= 1'b0;
            r_last_reg   <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_latch) begin
                r_win  <= w_win_idx;
                r_ptr  <= w_next_ptr;
                r_bank <= w_sel_bank;
                r_reg  <= w_sel_reg;
                r_val  <= w_sel_val;
            end
            if (w_done) begin
                r_last_valid <= 1'b1;
                r_last_bank  <= r_bank;
                r_last_reg   <= r_reg;
            end
        end
    end

    // Registered pin drivers derived from the state being entered this edge.
    always_ff @(posedge i_mclk) begin
        if (!i_ic) begin
            r_cs      <= 1'b1;
            r_wr      <= 1'b1;
            r_address <= 2'b00;
            r_data    <= 8'h00;
            r_ack     <= 2'b00;
            r_busy    <= 1'b0;
        end else begin
            r_cs   <= 1'b1;
            r_wr   <= 1'b1;
            r_ack  <= 2'b00;
            r_busy <= (w_next_state != ST_IDLE);
            case (w_next_state)
                ST_ADDR_WR: begin
                    r_cs      <= 1'b0;
                    r_wr      <= 1'b0;
                    r_address <= {w_nbank, 1'b0};
                    r_data    <= w_nreg;
                end
                ST_DATA_WR: begin
                    r_cs      <= 1'b0;
                    r_wr      <= 1'b0;
                    r_address <= {w_nbank, 1'b1};
                    r_data    <= w_nval;
                end
                default: ;
            endcase
            if (w_done) r_ack <= {r_win, ~r_win};
        end
    end

    assign o_ack       = r_ack;
    assign o_busy      = r_busy;
    assign o_cs        = r_cs;
    assign o_wr        = r_wr;
    assign o_rd        = 1'b1;
    assign o_address   = r_address;
    assign o_data      = r_data;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ym3438_bus_arb.sv
// Directed bench for the YM3438 bus arbiter: reset, single write, address
// skip, bank change, two-port contention and reset during a data strobe.
module tb_ym3438_bus_arb;
    import ym3438_arb_pkg::*;

    logic            clk;
    logic            ic;
    logic [1:0]      req;
    logic [1:0]      bank;
    logic [1:0][7:0] regs;
    logic [1:0][7:0] vals;
    logic [1:0]      ack;
    logic            busy, cs, wr, rd;
    logic [1:0]      address;
    logic [7:0]      data;
    arb_state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    ym3438_bus_arb dut (
        .i_mclk      (clk),
        .i_ic        (ic),
        .i_req       (req),
        .i_bank      (bank),
        .i_reg       (regs),
        .i_val       (vals),
        .o_ack       (ack),
        .o_busy      (busy),
        .o_cs        (cs),
        .o_wr        (wr),
        .o_rd        (rd),
        .o_address   (address),
        .o_data      (data),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cs"},    32'(cs), 1);
        check({tag, "_wr"},    32'(wr), 1);
        check({tag, "_rd"},    32'(rd), 1);
        check({tag, "_addr"},  32'(address), 0);
        check({tag, "_data"},  32'(data), 0);
        check({tag, "_ack"},   32'(ack), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Called on the negedge right after the edge that granted the write.
    // Returns on the negedge where the ack pulse is visible.
    task automatic observe(input int port, input logic b, input logic [7:0] r,
                           input logic [7:0] v, input logic with_addr);
        logic [1:0] ack_exp;
        ack_exp = (port == 1) ? 2'b10 : 2'b01;
        if (with_addr) begin
            check("astb_cs",   32'(cs), 0);
            check("astb_wr",   32'(wr), 0);
            check("astb_addr", 32'(address), 32'({b, 1'b0}));
            check("astb_data", 32'(data), 32'(r));
            check("astb_busy", 32'(busy), 1);
            tick(11);
            check("astb_end_cs",   32'(cs), 0);
            check("astb_end_data", 32'(data), 32'(r));
            tick(1);
            check("gap_cs",   32'(cs), 1);
            check("gap_addr", 32'(address), 32'({b, 1'b0}));
            check("gap_data", 32'(data), 32'(r));
            tick(11);
            check("gap_end_cs", 32'(cs), 1);
            tick(1);
        end
        check("dstb_cs",   32'(cs), 0);
        check("dstb_wr",   32'(wr), 0);
        check("dstb_addr", 32'(address), 32'({b, 1'b1}));
        check("dstb_data", 32'(data), 32'(v));
        check("dstb_ack",  32'(ack), 0);
        tick(11);
        check("dstb_end_cs",  32'(cs), 0);
        check("dstb_end_ack", 32'(ack), 0);
        tick(1);
        check("ack_pulse", 32'(ack), 32'(ack_exp));
        check("ack_cs",    32'(cs), 1);
        check("ack_addr",  32'(address), 32'({b, 1'b1}));
        check("ack_data",  32'(data), 32'(v));
        check("ack_busy",  32'(busy), 1);
    endtask

    // From the ack negedge: busy stays high 192 samples with CS high, no extra ack.
    task automatic busy_hold();
        int n;
        int cs_low;
        int ack_extra;
        n = 0;
        cs_low = 0;
        ack_extra = 0;
        while (busy === 1'b1 && n < 400) begin
            if (cs !== 1'b1) cs_low++;
            if (n > 0 && ack !== 2'b00) ack_extra++;
            n++;
            tick(1);
        end
        check("busy_len",    32'(n), 192);
        check("busy_cs_low", 32'(cs_low), 0);
        check("busy_ack",    32'(ack_extra), 0);
        check("idle_state",  32'(dbg_state), 32'(ST_IDLE));
    endtask

    // From the ack negedge with requests pending: count CS-high samples until the next strobe.
    task automatic cs_gap();
        int n;
        n = 0;
        while (cs === 1'b1 && n < 400) begin
            n++;
            tick(1);
        end
        check("cs_gap_len", 32'(n), 193);
    endtask

    // Directed sequence
    initial begin
        ic   = 1'b0;
        req  = 2'b11;
        bank = 2'b10;
        regs[0] = 8'h28; vals[0] = 8'hF0;
        regs[1] = 8'hA4; vals[1] = 8'h22;

        // Reset held three cycles with both ports requesting
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_reset("rst");
        end

        // Release: port 0 wins first; single full write
        ic = 1'b1;
        tick(1);
        observe(0, 1'b0, 8'h28, 8'hF0, 1'b1);
        req[0] = 1'b0;
        busy_hold();

        // Port 1 has been waiting and is granted next
        tick(1);
        observe(1, 1'b1, 8'hA4, 8'h22, 1'b1);
        req[1] = 1'b0;
        busy_hold();

        // Same bank/reg again: address strobe skipped
        vals[1] = 8'h23;
        req[1]  = 1'b1;
        tick(1);
        observe(1, 1'b1, 8'hA4, 8'h23, 1'b0);
        req[1] = 1'b0;
        busy_hold();

        // Bank change on the same register number
        bank[1] = 1'b0; regs[1] = 8'h30; vals[1] = 8'h01;
        req[1]  = 1'b1;
        tick(1);
        observe(1, 1'b0, 8'h30, 8'h01, 1'b1);
        req[1] = 1'b0;
        busy_hold();
        bank[1] = 1'b1; vals[1] = 8'h02;
        req[1]  = 1'b1;
        tick(1);
        observe(1, 1'b1, 8'h30, 8'h02, 1'b1);
        check("bank1_addr", 32'(address), 32'(2'b11));
        req[1] = 1'b0;
        busy_hold();

        // Contention: both ports request continuously
        bank = 2'b10;
        regs[0] = 8'h40; vals[0] = 8'h11;
        regs[1] = 8'h50; vals[1] = 8'h22;
        req = 2'b11;
        tick(1);
        observe(0, 1'b0, 8'h40, 8'h11, 1'b1);
        cs_gap();
        observe(1, 1'b1, 8'h50, 8'h22, 1'b1);
        cs_gap();
        observe(0, 1'b0, 8'h40, 8'h11, 1'b1);
        cs_gap();
        observe(1, 1'b1, 8'h50, 8'h22, 1'b1);
        req = 2'b00;
        busy_hold();

        // Reset during a data strobe (skip path, same reg as last write)
        vals[1] = 8'h44;
        req = 2'b10;
        tick(1);
        check("mid_dstb_cs",   32'(cs), 0);
        check("mid_dstb_addr", 32'(address), 32'(2'b11));
        check("mid_dstb_data", 32'(data), 32'(8'h44));
        tick(5);
        ic = 1'b0;
        tick(1);
        check_reset("midrst");
        ic = 1'b1;
        tick(1);
        // last_valid was cleared, so the same register needs an address strobe
        observe(1, 1'b1, 8'h50, 8'h44, 1'b1);
        req = 2'b00;
        busy_hold();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
